// File: rtl/window_streamer.sv
// Captures one board line and streams its 6-cell windows over a valid/ready handshake.
// Optional macro WINDOW_SKIP_DEAD_EN drops windows holding both white and black stones.
module window_streamer #(
   parameter int LINE_MAX = 19
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                line_valid,
   output logic                line_ready,
   input  logic [LINE_MAX-1:0] line_white,
   input  logic [LINE_MAX-1:0] line_black,
   input  logic [LINE_MAX-1:0] line_marks_w,
   input  logic [LINE_MAX-1:0] line_marks_b,
   input  logic [4:0]          line_len,
   output logic                win_valid,
   input  logic                win_ready,
   output logic [5:0]          window_white,
   output logic [5:0]          window_black,
   output logic [5:0]          marks_w,
   output logic [5:0]          marks_b,
   output logic [4:0]          win_pos,
   output logic                scan_done,
   output logic                len_err
);

   typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_e;

   state_e              state_q, state_d;
   logic [4:0]          pos_q, pos_d;
   logic [4:0]          len_q;
   logic [LINE_MAX-1:0] white_q, black_q, mw_q, mb_q;
   logic                len_err_q, len_err_d;
   logic                capture;
   logic                len_ok;
   logic                last;
   logic                dead;

   assign len_ok = (line_len >= 5'd6) && ({27'd0, line_len} <= 32'(LINE_MAX));
   assign last   = (pos_q == (len_q - 5'd6));

   // Window cell k is captured cell pos+k; pos never exceeds LINE_MAX-6.
   always_comb begin
      window_white = 6'(white_q >> pos_q);
      window_black = 6'(black_q >> pos_q);
      marks_w      = 6'(mw_q >> pos_q);
      marks_b      = 6'(mb_q >> pos_q);
      win_pos      = pos_q;
   end

`ifdef WINDOW_SKIP_DEAD_EN
   assign dead = (|window_white) && (|window_black);
`else
   assign dead = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pos_q     <= '0;
         len_q     <= '0;
         white_q   <= '0;
         black_q   <= '0;
         mw_q      <= '0;
         mb_q      <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         len_err_q <= len_err_d;
         if (capture) begin
            len_q   <= line_len;
            white_q <= line_white;
            black_q <= line_black;
            mw_q    <= line_marks_w;
            mb_q    <= line_marks_b;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      capture   = 1'b0;
      len_err_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (line_valid) begin
               if (len_ok) begin
                  state_d = STREAM;
                  pos_d   = '0;
                  capture = 1'b1;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         STREAM: begin
            // A dead window advances exactly like an accepted one, just without a handshake.
            if ((win_valid && win_ready) || dead) begin
               if (last) state_d = FINISH;
               else      pos_d   = pos_q + 5'd1;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      line_ready = (state_q == IDLE);
      win_valid  = (state_q == STREAM) && !dead;
      scan_done  = (state_q == FINISH);
      len_err    = len_err_q;
   end

endmodule

// File: tb/tb_window_streamer.sv
// Table-driven and randomized bench for window_streamer with a queue-based window model.
module tb_window_streamer;
   localparam int LM = 19;

   logic          clk, rst, line_valid, line_ready, win_valid, win_ready;
   logic [LM-1:0] line_white, line_black, line_marks_w, line_marks_b;
   logic [4:0]    line_len, win_pos;
   logic [5:0]    window_white, window_black, marks_w, marks_b;
   logic          scan_done, len_err;

   int errors = 0;
   int checks = 0;

   window_streamer #(.LINE_MAX(LM)) dut (
      .clk(clk), .rst(rst), .line_valid(line_valid), .line_ready(line_ready),
      .line_white(line_white), .line_black(line_black),
      .line_marks_w(line_marks_w), .line_marks_b(line_marks_b), .line_len(line_len),
      .win_valid(win_valid), .win_ready(win_ready),
      .window_white(window_white), .window_black(window_black),
      .marks_w(marks_w), .marks_b(marks_b), .win_pos(win_pos),
      .scan_done(scan_done), .len_err(len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]    len;
      logic [LM-1:0] w, b, mw, mb;
      int            exp_n;
      bit            exp_err;
      int            mode;
   } vec_t;

   typedef struct {
      logic [5:0] w, b, mw, mb;
      logic [4:0] pos;
   } win_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Entered and left just after a falling edge.
   task automatic run_line(input logic [4:0] len, input logic [LM-1:0] w, input logic [LM-1:0] b,
                           input logic [LM-1:0] mw, input logic [LM-1:0] mb,
                           input int exp_n, input int mode, input int abort_at);
      win_t q[$];
      win_t e;
      bit   err, done;
      int   n, stall;
      err = (len < 5'd6) || (int'(len) > LM);
      if (!err) begin
         for (int p = 0; p + 6 <= int'(len); p++) begin
            for (int k = 0; k < 6; k++) begin
               e.w[k] = w[p+k]; e.b[k] = b[p+k]; e.mw[k] = mw[p+k]; e.mb[k] = mb[p+k];
            end
            e.pos = 5'(p);
`ifdef WINDOW_SKIP_DEAD_EN
            if ((|e.w) && (|e.b)) continue;
`endif
            q.push_back(e);
         end
      end
      chk("idle_ready", line_ready, 1);
      line_valid = 1'b1; line_len = len;
      line_white = w; line_black = b; line_marks_w = mw; line_marks_b = mb;
      win_ready = 1'b1;
      @(negedge clk);
      if (err) begin
         line_valid = 1'b0;
         chk("len_err_pulse", len_err, 1);
         chk("err_no_window", win_valid, 0);
         chk("err_ready", line_ready, 1);
         @(negedge clk);
         chk("len_err_clear", len_err, 0);
         chk("err_ready2", line_ready, 1);
         chk("err_no_window2", win_valid, 0);
         return;
      end
      n = 0; done = 0; stall = 0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         line_valid   = 1'($urandom);
         line_white   = LM'($urandom); line_black   = LM'($urandom);
         line_marks_w = LM'($urandom); line_marks_b = LM'($urandom);
         line_len     = 5'($urandom);
         if (abort_at >= 0 && win_valid && int'(win_pos) == abort_at) begin
            rst = 1'b1; win_ready = 1'b0; line_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_win_valid", win_valid, 0);
            chk("rst_line_ready", line_ready, 1);
            chk("rst_win_pos", win_pos, 0);
            chk("rst_white", window_white, 0);
            chk("rst_scan_done", scan_done, 0);
            return;
         end
         if (scan_done) begin
            line_valid = 1'b0;
            chk("done_queue_empty", q.size(), 0);
            chk("done_win_valid", win_valid, 0);
            chk("done_len_err", len_err, 0);
            done = 1;
         end else begin
            chk("stream_ready_low", line_ready, 0);
`ifndef WINDOW_SKIP_DEAD_EN
            chk("no_bubble", win_valid, 1);
`endif
            if (win_valid) begin
               if (q.size() == 0) begin
                  chk("extra_window", 1, 0);
               end else begin
                  chk("win_pos", win_pos, q[0].pos);
                  chk("win_white", window_white, q[0].w);
                  chk("win_black", window_black, q[0].b);
                  chk("marks_w", marks_w, q[0].mw);
                  chk("marks_b", marks_b, q[0].mb);
               end
            end
         end
         case (mode)
            1:       win_ready = 1'($urandom);
            2:       if (win_valid && win_pos == 5'd2 && stall < 3) begin win_ready = 1'b0; stall++; end
                     else win_ready = 1'b1;
            default: win_ready = 1'b1;
         endcase
         if (!done && win_valid && win_ready && q.size() > 0) begin
            void'(q.pop_front());
            n++;
         end
         if (!done) @(negedge clk);
      end
      line_valid = 1'b0;
      if (!done) chk("scan_timeout", 0, 1);
      if (exp_n >= 0) chk("window_count", n, exp_n);
      if (mode == 2) chk("stall_cycles", stall, 3);
      @(negedge clk);
      chk("done_one_cycle", scan_done, 0);
      chk("back_idle_ready", line_ready, 1);
      chk("back_idle_valid", win_valid, 0);
   endtask

   vec_t vecs[$];

   initial begin
      rst = 1'b1; line_valid = 1'b0; win_ready = 1'b0; line_len = '0;
      line_white = '0; line_black = '0; line_marks_w = '0; line_marks_b = '0;

      vecs.push_back('{5'd19, 19'h0,     19'h0,     19'h0,     19'h0,     14, 1'b0, 0});
      vecs.push_back('{5'd6,  19'h0003F, 19'h0,     19'h0,     19'h0,     1,  1'b0, 0});
      vecs.push_back('{5'd10, 19'h002A5, 19'h0,     19'h000F0, 19'h00305, 5,  1'b0, 2});
      vecs.push_back('{5'd4,  19'h0000F, 19'h0,     19'h0,     19'h0,     0,  1'b1, 0});
      vecs.push_back('{5'd0,  19'h0,     19'h0,     19'h0,     19'h0,     0,  1'b1, 0});
      vecs.push_back('{5'd5,  19'h0,     19'h0001F, 19'h0,     19'h0,     0,  1'b1, 0});
      vecs.push_back('{5'd20, 19'h7FFFF, 19'h0,     19'h0,     19'h0,     0,  1'b1, 0});
      vecs.push_back('{5'd7,  19'h0,     19'h0007F, 19'h00041, 19'h0,     2,  1'b0, 1});
      vecs.push_back('{5'd19, 19'h0,     19'h4C3A1, 19'h7FFFF, 19'h55555, 14, 1'b0, 1});
`ifdef WINDOW_SKIP_DEAD_EN
      vecs.push_back('{5'd8,  19'h00001, 19'h00020, 19'h0,     19'h0,     2,  1'b0, 0});
`else
      vecs.push_back('{5'd8,  19'h00001, 19'h00020, 19'h0,     19'h0,     3,  1'b0, 0});
`endif

      repeat (2) @(negedge clk);
      chk("reset_win_valid", win_valid, 0);
      chk("reset_scan_done", scan_done, 0);
      chk("reset_len_err", len_err, 0);
      chk("reset_line_ready", line_ready, 1);
      chk("reset_win_pos", win_pos, 0);
      chk("reset_buses", {window_white, window_black, marks_w, marks_b}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", line_ready, 1);
      chk("post_reset_valid", win_valid, 0);

      for (int i = 0; i < vecs.size(); i++)
         run_line(vecs[i].len, vecs[i].w, vecs[i].b, vecs[i].mw, vecs[i].mb,
                  vecs[i].exp_n, vecs[i].mode, -1);

      run_line(5'd19, 19'h12345, 19'h0, 19'h0F0F0, 19'h0, -1, 0, 7);
      run_line(5'd19, 19'h0, 19'h31C07, 19'h0, 19'h7A5A5, 14, 0, -1);

      for (int i = 0; i < 40; i++) begin
         logic [LM-1:0] w, b;
         w = LM'($urandom & $urandom);
         b = LM'($urandom & $urandom) & ~w;
         run_line(5'($urandom_range(0, 22)), w, b, LM'($urandom), LM'($urandom), -1, 1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/window_streamer.md
WINDOW_STREAMER -- requirements
Module: window_streamer

Interface
REQ-001 SHALL have parameter LINE_MAX, default 19, maximum cells in one board line (row, column or diagonal).
REQ-002 SHALL have port clk, input, 1, sole clock, all state rising-edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port line_valid, input, 1, producer offers a line.
REQ-005 SHALL have port line_ready, output, 1, block can accept a line.
REQ-006 SHALL have port line_white, input, LINE_MAX, white stones; bit i = cell i.
REQ-007 SHALL have port line_black, input, LINE_MAX, black stones; bit i = cell i.
REQ-008 SHALL have ports line_marks_w and line_marks_b, input, LINE_MAX each, per-cell marks per colour.
REQ-009 SHALL have port line_len, input, 5, valid cells in the line (0..LINE_MAX).
REQ-010 SHALL have port win_valid, output, 1, window outputs hold a valid window.
REQ-011 SHALL have port win_ready, input, 1, consumer accepts the window.
REQ-012 SHALL have ports window_white and window_black, output, 6 each (index 0..5), stones of the current window.
REQ-013 SHALL have ports marks_w and marks_b, output, 6 each, marks of the current window.
REQ-014 SHALL have port win_pos, output, 5, line index of window cell 0.
REQ-015 SHALL have port scan_done, output, 1, one-cycle pulse when a line is finished.
REQ-016 SHALL have port len_err, output, 1, one-cycle pulse on line_len < 6 or line_len > LINE_MAX.

Function
REQ-017 SHALL implement states IDLE, STREAM, FINISH.
REQ-018 IDLE: line_ready = 1; line_valid high captures all line inputs into internal registers, sets pos = 0, goes to STREAM.
REQ-019 IDLE capture with an invalid line_len SHALL pulse len_err the next cycle, produce no windows, stay in IDLE.
REQ-020 STREAM: line_ready = 0; window cell k SHALL equal captured line cell pos+k, k = 0..5, for all four window buses.
REQ-021 First win_valid SHALL rise the cycle after the capture edge, with win_pos = 0.
REQ-022 While win_valid = 1 and win_ready = 0, all window outputs and win_pos SHALL hold stable.
REQ-023 On win_valid and win_ready in the same cycle, pos SHALL advance by 1; the next window SHALL be valid the following cycle with no bubble.
REQ-024 The window at pos = line_len-6 SHALL be the last; its acceptance SHALL move the block to FINISH.
REQ-025 FINISH SHALL last one cycle, pulse scan_done, win_valid = 0, then return to IDLE.
REQ-026 Number of windows per line SHALL be line_len-5; line_len = 6 yields exactly one window.
REQ-027 line_valid asserted outside IDLE SHALL be ignored (line_ready low); the captured line SHALL stay unchanged.
REQ-028 win_ready asserted with win_valid low SHALL have no effect.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, pos = 0, and all captured line registers to 0, in any state including mid-stream.
REQ-030 Output values after reset SHALL be: win_valid = 0, scan_done = 0, len_err = 0, line_ready = 1, window buses 0, win_pos = 0.

Configuration
REQ-031 Macro WINDOW_SKIP_DEAD_EN, when defined, SHALL suppress dead windows, i.e. windows holding at least one white and at least one black stone.
REQ-032 Handling of a dead window with the macro defined:
- the window SHALL spend one cycle at win_valid = 0 while pos advances;
- a dead last window SHALL go directly to FINISH.
REQ-033 With the macro undefined, every window SHALL be emitted regardless of content.

Verification
REQ-034 Empty line, line_len 19, win_ready tied 1 -> 14 windows on consecutive cycles, win_pos 0..13, all buses 0, then one scan_done pulse.
REQ-035 line_white = 0x0003F, line_len 6 -> one window, window_white = 6'b111111, win_pos 0, then scan_done.
REQ-036 line_len 10, win_ready low for 3 cycles at pos 2 -> win_pos holds 2 with buses stable, then advances; 5 windows total.
REQ-037 line_len 4 -> len_err pulse the cycle after capture, no win_valid, line_ready stays 1.
REQ-038 rst asserted at pos 7 of a 19-cell line -> next cycle win_valid 0, line_ready 1; a new line streams from pos 0.
REQ-039 WINDOW_SKIP_DEAD_EN defined, white at cell 0, black at cell 5, line_len 8 -> window 0 skipped; windows at pos 1 and 2 emitted.
